adder_tree_feeder: RTL and testbench
====================================

// Module: adder_tree_feeder
// PURPOSE
//  Byte-stream to parallel-operand packer sitting in front of adder_tree.
//  Accepts W-bit samples one per cycle over a valid/ready handshake and packs
//  N of them into the lanes a..h. It then presents the full operand set with
//  out_valid and holds it until the consumer takes it.
//  Also computes the expected sum serially, so the tree output y can be
//  checked against exp_sum in-system and in simulation.
// PARAMETERS
//  W      8   sample / lane width in bits
//  N      8   number of lanes (the a..h ports require N=8)
//  SUM_W  11  width of exp_sum, W+$clog2(N); must match adder_tree y width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      synchronous clear; discards a partial or held set
//  in_data    in   W      input sample
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block can accept in_data
//  a..h       out  W each operand lanes 0..7 to adder_tree (a = first sample)
//  out_valid  out  1      lanes a..h and exp_sum are complete and stable
//  out_ready  in   1      consumer accepts the current set
//  exp_sum    out  SUM_W  sum of the N packed samples, zero-extended
//  fill_cnt   out  4      number of samples packed into the current set, 0..N
// BEHAVIOUR
//  Reset (rst_n=0, async): state=FILL, fill_cnt=0, exp_sum=0, a..h=0,
//   out_valid=0, in_ready=1 after release.
//  FSM, 2 states:
//   FILL: in_ready=1, out_valid=0.
//    On in_valid&in_ready: lane[fill_cnt]<=in_data; exp_sum<=exp_sum+in_data;
//    fill_cnt<=fill_cnt+1.
//    When the Nth sample is accepted (fill_cnt==N-1): go to HOLD.
//    out_valid=1 from the next cycle, so latency is 1 cycle after the last
//    accepted sample.
//   HOLD: in_ready=0, out_valid=1; a..h and exp_sum are held stable.
//    On out_valid&out_ready: go to FILL with fill_cnt=0 and exp_sum=0.
//    Lanes keep their old values until they are overwritten.
//    in_ready returns to 1 on the following cycle; no accept happens in the
//    handshake cycle itself.
//  in_valid gaps in FILL: state is held and nothing is accepted.
//  out_ready while out_valid=0: ignored.
//  exp_sum never overflows: max N*(2^W-1) = 2040 fits SUM_W=11.
//  flush (sync, any state): same effect as reset, but lanes a..h are left
//   unchanged. Flush has priority over a simultaneous input or output
//   handshake, and that handshake is dropped.
//  Async reset mid-fill or mid-hold: all partial data is discarded.
//   out_valid falls immediately.
//  Any lanes not written since reset read 0.
// TESTING
//  1 Send 1,2,...,8 back-to-back after reset; out_ready=1 -> a..h=1..8,
//    exp_sum=36, out_valid high 1 cycle after the 8th accept, then
//    in_ready=1 the next cycle.
//  2 Send eight 0xFF samples -> exp_sum=11'h7F8. Connect adder_tree and check
//    y==exp_sum once the tree latency has elapsed.
//  3 Send a full set with out_ready=0 for 10 cycles -> out_valid and lanes are
//    stable, in_ready=0, and extra in_valid beats are not accepted
//    (fill_cnt=8).
//  4 Send random in_valid gaps across 8 samples -> exactly 8 accepts,
//    correct lane order, fill_cnt increments only on handshakes.
//  5 Pulse rst_n low after 3 samples -> fill_cnt=0, exp_sum=0, out_valid=0
//    immediately. A fresh set 10..17 gives exp_sum=108.
//  6 Assert flush together with the 5th in_valid -> that sample is dropped,
//    fill_cnt=0. Assert flush during HOLD with out_ready=1 -> returns to FILL
//    with no extra handshake.

Source files
------------

// File: rtl/adder_tree_feeder_if.sv
// Handshake bundle between a sample producer and adder_tree_feeder.
// The producer/consumer side uses master; the feeder uses slave.
interface adder_tree_feeder_if #(
  parameter int W     = 8,
  parameter int SUM_W = 11
);
  logic             flush;
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a, b, c, d, e, f, g, h;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] exp_sum;
  logic [3:0]       fill_cnt;

  modport master (
    output flush, in_data, in_valid, out_ready,
    input  in_ready, a, b, c, d, e, f, g, h, out_valid, exp_sum, fill_cnt
  );

  modport slave (
    input  flush, in_data, in_valid, out_ready,
    output in_ready, a, b, c, d, e, f, g, h, out_valid, exp_sum, fill_cnt
  );
endinterface

// File: rtl/adder_tree_feeder.sv
// Packs N serial samples into parallel lanes a..h for adder_tree and keeps a
// serially accumulated reference sum alongside them.
//
// state | meaning
// FILL  | accepting samples into lane[fill_cnt], accumulating exp_sum
// HOLD  | full set presented with out_valid, waiting for out_ready
module adder_tree_feeder #(
  parameter int W     = 8,
  parameter int N     = 8,
  parameter int SUM_W = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_tree_feeder_if.slave bus
);
  localparam int IDX_W = $clog2(N);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  logic [W-1:0]     lane [N];
  logic [3:0]       fill_cnt_q;
  logic [SUM_W-1:0] exp_sum_q;
  logic             in_ready_q;
  logic             out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      fill_cnt_q  <= '0;
      exp_sum_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) lane[i] <= '0;
    end else if (bus.flush) begin
      // Lanes are deliberately left alone; only the set bookkeeping clears.
      state       <= FILL;
      fill_cnt_q  <= '0;
      exp_sum_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid && in_ready_q) begin
            lane[fill_cnt_q[IDX_W-1:0]] <= bus.in_data;
            exp_sum_q  <= exp_sum_q + SUM_W'(bus.in_data);
            fill_cnt_q <= fill_cnt_q + 4'd1;
            if (fill_cnt_q == 4'(N - 1)) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            state       <= FILL;
            fill_cnt_q  <= '0;
            exp_sum_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.exp_sum   = exp_sum_q;
  assign bus.fill_cnt  = fill_cnt_q;
  assign bus.a = lane[0];
  assign bus.b = lane[1];
  assign bus.c = lane[2];
  assign bus.d = lane[3];
  assign bus.e = lane[4];
  assign bus.f = lane[5];
  assign bus.g = lane[6];
  assign bus.h = lane[7];
endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed bench for adder_tree_feeder: inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_adder_tree_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  adder_tree_feeder_if #(.W(8), .SUM_W(11)) ifc ();

  adder_tree_feeder #(.W(8), .N(8), .SUM_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // Offer one sample until accepted (bounded), returning at the falling edge
  // after the accepting rising edge.
  task automatic send(input logic [7:0] dat);
    int n = 0;
    ifc.in_data  = dat;
    ifc.in_valid = 1'b1;
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", ifc.in_ready, n);
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", ifc.out_valid); end
    n_cmp++; if (ifc.fill_cnt !== 4'd0) begin n_err++; $display("FAIL rst_fill_cnt: got %0d want 0", ifc.fill_cnt); end
    n_cmp++; if (ifc.exp_sum !== 11'd0) begin n_err++; $display("FAIL rst_exp_sum: got %0d want 0", ifc.exp_sum); end
    n_cmp++; if ({ifc.a, ifc.h} !== 16'h0000) begin n_err++; $display("FAIL rst_lanes: got a=%0h h=%0h want 0", ifc.a, ifc.h); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", ifc.in_ready); end
  endtask

  task automatic test_basic();
    ifc.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i));
    n_cmp++; if (ifc.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid: got %0b want 1", ifc.out_valid); end
    n_cmp++; if ({ifc.a, ifc.b, ifc.c, ifc.d, ifc.e, ifc.f, ifc.g, ifc.h} !== 64'h0102030405060708) begin
      n_err++; $display("FAIL basic_lanes: got %h want 0102030405060708", {ifc.a, ifc.b, ifc.c, ifc.d, ifc.e, ifc.f, ifc.g, ifc.h});
    end
    n_cmp++; if (ifc.exp_sum !== 11'd36) begin n_err++; $display("FAIL basic_exp_sum: got %0d want 36", ifc.exp_sum); end
    n_cmp++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_hold: got %0b want 0", ifc.in_ready); end
    @(negedge clk);
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_release_valid: got %0b want 0", ifc.out_valid); end
    n_cmp++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_release_ready: got %0b want 1", ifc.in_ready); end
    n_cmp++; if (ifc.fill_cnt !== 4'd0 || ifc.exp_sum !== 11'd0) begin
      n_err++; $display("FAIL basic_release_clear: got fill=%0d sum=%0d want 0/0", ifc.fill_cnt, ifc.exp_sum);
    end
    n_cmp++; if (ifc.a !== 8'd1) begin n_err++; $display("FAIL basic_lane_kept: got a=%0d want 1", ifc.a); end
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_full_scale_hold();
    logic [11:0] tree_y;
    for (int i = 0; i < 8; i++) send(8'hFF);
    n_cmp++; if (ifc.exp_sum !== 11'h7F8) begin n_err++; $display("FAIL ff_exp_sum: got %h want 7f8", ifc.exp_sum); end
    // Stand-in for adder_tree: sum the presented lanes directly.
    tree_y = 12'(ifc.a) + 12'(ifc.b) + 12'(ifc.c) + 12'(ifc.d) + 12'(ifc.e) + 12'(ifc.f) + 12'(ifc.g) + 12'(ifc.h);
    n_cmp++; if (tree_y !== 12'd2040) begin n_err++; $display("FAIL ff_tree_y: got %0d want 2040", tree_y); end
    ifc.in_data  = 8'h55;
    ifc.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.fill_cnt !== 4'd8) begin
        n_err++; $display("FAIL hold_ctrl[%0d]: got valid=%0b ready=%0b fill=%0d want 1/0/8", k, ifc.out_valid, ifc.in_ready, ifc.fill_cnt);
      end
      n_cmp++; if (ifc.a !== 8'hFF || ifc.h !== 8'hFF || ifc.exp_sum !== 11'h7F8) begin
        n_err++; $display("FAIL hold_data[%0d]: got a=%h h=%h sum=%h want ff/ff/7f8", k, ifc.a, ifc.h, ifc.exp_sum);
      end
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    n_cmp++; if (ifc.out_valid !== 1'b0 || ifc.fill_cnt !== 4'd0) begin
      n_err++; $display("FAIL hold_release: got valid=%0b fill=%0d want 0/0", ifc.out_valid, ifc.fill_cnt);
    end
  endtask

  task automatic test_gaps();
    int gaps [8] = '{0, 2, 1, 3, 0, 1, 2, 0};
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        @(negedge clk);
        n_cmp++; if (ifc.fill_cnt !== 4'(i)) begin n_err++; $display("FAIL gap_fill[%0d]: got %0d want %0d", i, ifc.fill_cnt, i); end
      end
      send(8'h10 + 8'(i));
    end
    n_cmp++; if ({ifc.a, ifc.b, ifc.c, ifc.d, ifc.e, ifc.f, ifc.g, ifc.h} !== 64'h1011121314151617) begin
      n_err++; $display("FAIL gap_lanes: got %h want 1011121314151617", {ifc.a, ifc.b, ifc.c, ifc.d, ifc.e, ifc.f, ifc.g, ifc.h});
    end
    n_cmp++; if (ifc.exp_sum !== 11'd156 || ifc.fill_cnt !== 4'd8) begin
      n_err++; $display("FAIL gap_sum: got sum=%0d fill=%0d want 156/8", ifc.exp_sum, ifc.fill_cnt);
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    send(8'd5); send(8'd6); send(8'd7);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ifc.fill_cnt !== 4'd0 || ifc.exp_sum !== 11'd0 || ifc.out_valid !== 1'b0) begin
      n_err++; $display("FAIL arst_fill: got fill=%0d sum=%0d valid=%0b want 0/0/0", ifc.fill_cnt, ifc.exp_sum, ifc.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 10; i <= 17; i++) send(8'(i));
    n_cmp++; if (ifc.exp_sum !== 11'd108 || ifc.out_valid !== 1'b1) begin
      n_err++; $display("FAIL arst_fresh: got sum=%0d valid=%0b want 108/1", ifc.exp_sum, ifc.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ifc.out_valid !== 1'b0 || ifc.a !== 8'd0) begin
      n_err++; $display("FAIL arst_hold: got valid=%0b a=%0d want 0/0", ifc.out_valid, ifc.a);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 4; i++) send(8'(i));
    ifc.in_data  = 8'd5;
    ifc.in_valid = 1'b1;
    ifc.flush    = 1'b1;
    @(negedge clk);
    ifc.flush    = 1'b0;
    ifc.in_valid = 1'b0;
    n_cmp++; if (ifc.fill_cnt !== 4'd0 || ifc.exp_sum !== 11'd0 || ifc.in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_fill: got fill=%0d sum=%0d ready=%0b want 0/0/1", ifc.fill_cnt, ifc.exp_sum, ifc.in_ready);
    end
    n_cmp++; if (ifc.a !== 8'd1 || ifc.d !== 8'd4 || ifc.e !== 8'd0) begin
      n_err++; $display("FAIL flush_lanes: got a=%0d d=%0d e=%0d want 1/4/0", ifc.a, ifc.d, ifc.e);
    end
    for (int i = 0; i < 8; i++) send(8'h21 + 8'(i));
    n_cmp++; if (ifc.exp_sum !== 11'd292 || ifc.out_valid !== 1'b1) begin
      n_err++; $display("FAIL flush_set: got sum=%0d valid=%0b want 292/1", ifc.exp_sum, ifc.out_valid);
    end
    ifc.flush     = 1'b1;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.flush     = 1'b0;
    ifc.out_ready = 1'b0;
    n_cmp++; if (ifc.out_valid !== 1'b0 || ifc.fill_cnt !== 4'd0 || ifc.in_ready !== 1'b1 || ifc.a !== 8'h21) begin
      n_err++; $display("FAIL flush_hold: got valid=%0b fill=%0d ready=%0b a=%h want 0/0/1/21", ifc.out_valid, ifc.fill_cnt, ifc.in_ready, ifc.a);
    end
    send(8'h99);
    n_cmp++; if (ifc.a !== 8'h99 || ifc.fill_cnt !== 4'd1 || ifc.exp_sum !== 11'h099) begin
      n_err++; $display("FAIL flush_next: got a=%h fill=%0d sum=%h want 99/1/099", ifc.a, ifc.fill_cnt, ifc.exp_sum);
    end
  endtask

  initial begin
    ifc.flush     = 1'b0;
    ifc.in_data   = 8'h00;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_full_scale_hold();
    test_gaps();
    test_async_reset();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
